// File: rtl/mesh_pkg.sv
// Shared definitions for the XY mesh router: port indices, address field
// widths and the dimension-ordered route function.
package mesh_pkg;

    localparam int NUM_PORTS = 5;
    localparam int P_N       = 0;
    localparam int P_S       = 1;
    localparam int P_E       = 2;
    localparam int P_W       = 3;
    localparam int P_PE      = 4;

    localparam int ROW_W  = 8;
    localparam int COL_W  = 8;
    localparam int ADDR_W = ROW_W + COL_W;
    localparam int PORT_W = 3;

    typedef logic [PORT_W-1:0] port_idx_t;

    // Column is resolved before row so that XY routing stays deadlock free.
    function automatic port_idx_t route(input logic [ADDR_W-1:0] dest,
                                        input logic [ADDR_W-1:0] cur);
        logic [ROW_W-1:0] dr;
        logic [ROW_W-1:0] cr;
        logic [COL_W-1:0] dc;
        logic [COL_W-1:0] cc;
        dr = dest[ADDR_W-1:COL_W];
        cr = cur[ADDR_W-1:COL_W];
        dc = dest[COL_W-1:0];
        cc = cur[COL_W-1:0];
        if (dc > cc)
            return port_idx_t'(P_E);
        else if (dc < cc)
            return port_idx_t'(P_W);
        else if (dr > cr)
            return port_idx_t'(P_S);
        else if (dr < cr)
            return port_idx_t'(P_N);
        else
            return port_idx_t'(P_PE);
    endfunction

    function automatic port_idx_t wrap_add(input port_idx_t base, input int off);
        int s;
        s = int'(base) + off;
        return port_idx_t'(s % NUM_PORTS);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-input circular buffer with count-based full/empty flags.
// Works for any DEPTH >= 1, including non powers of two.
module router_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push, do_pop;

    // Full is not relaxed by a same-cycle pop: a full FIFO never accepts.
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push)
            wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        if (do_pop)
            rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (!do_push && do_pop)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mesh_router_xy.sv
// Five-port XY mesh router: input FIFOs, route compute, round-robin output
// arbiters, 1-flit output registers and edge drop. ROUTER_STATS_EN adds counters.
module mesh_router_xy
    import mesh_pkg::*;
#(
    parameter int          DATA_WIDTH      = 64,
    parameter int          DEPTH           = 1,
    parameter logic [15:0] CURRENT_ADDRESS = 16'h0000,
    parameter int          DST_LSB         = 32,
    parameter logic [4:0]  EDGE_MASK       = 5'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            polarity,
    input  logic [NUM_PORTS-1:0]            in_send,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_PORTS-1:0]            in_ready,
    output logic [NUM_PORTS-1:0]            out_send,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
    input  logic [NUM_PORTS-1:0]            out_ready,
    output logic                            err_drop,
    output logic                            flit_phase,
    output logic [NUM_PORTS*16-1:0]         stat_cnt
);

    logic [DATA_WIDTH-1:0] head [NUM_PORTS];
    port_idx_t             head_route [NUM_PORTS];
    logic [NUM_PORTS-1:0]  fifo_full, fifo_empty, head_valid, drop, pop;
    logic [NUM_PORTS-1:0]  req [NUM_PORTS];

    logic [NUM_PORTS-1:0]  grant;
    port_idx_t             winner [NUM_PORTS];
    port_idx_t             idx;
    port_idx_t             rr_ptr_q [NUM_PORTS];
    port_idx_t             rr_ptr_d [NUM_PORTS];

    logic [NUM_PORTS-1:0]  out_send_q, out_send_d;
    logic [DATA_WIDTH-1:0] out_data_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0] out_data_d [NUM_PORTS];
    logic                  err_drop_q, phase_q;

    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_in
        router_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .reset  (reset),
            .push_i (in_send[gp]),
            .data_i (in_data[gp*DATA_WIDTH +: DATA_WIDTH]),
            .pop_i  (pop[gp]),
            .data_o (head[gp]),
            .full_o (fifo_full[gp]),
            .empty_o(fifo_empty[gp])
        );

        assign in_ready[gp]   = !fifo_full[gp];
        assign head_valid[gp] = !fifo_empty[gp];
        assign head_route[gp] = route(head[gp][DST_LSB +: ADDR_W], CURRENT_ADDRESS);
        // A head bound for a missing neighbour is discarded without arbitration.
        assign drop[gp]       = head_valid[gp] && EDGE_MASK[head_route[gp]];
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                req[o][p] = head_valid[p] && !drop[p] && (head_route[p] == port_idx_t'(o));
            end
        end
    end

    always_comb begin
        pop = drop;
        idx = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            grant[o]      = 1'b0;
            winner[o]     = '0;
            rr_ptr_d[o]   = rr_ptr_q[o];
            out_send_d[o] = out_send_q[o] && !out_ready[o];
            out_data_d[o] = out_data_q[o];
            // The register can be refilled in the same cycle it is drained.
            if (!out_send_q[o] || out_ready[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = wrap_add(rr_ptr_q[o], k);
                    if (!grant[o] && req[o][idx]) begin
                        grant[o]  = 1'b1;
                        winner[o] = idx;
                    end
                end
            end
            if (grant[o]) begin
                pop[winner[o]] = 1'b1;
                rr_ptr_d[o]    = wrap_add(winner[o], 1);
                out_send_d[o]  = 1'b1;
                out_data_d[o]  = head[winner[o]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_send_q <= '0;
            err_drop_q <= 1'b0;
            phase_q    <= 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                out_data_q[o] <= '0;
                rr_ptr_q[o]   <= '0;
            end
        end else begin
            out_send_q <= out_send_d;
            err_drop_q <= |drop;
            phase_q    <= polarity;
            for (int o = 0; o < NUM_PORTS; o++) begin
                out_data_q[o] <= out_data_d[o];
                rr_ptr_q[o]   <= rr_ptr_d[o];
            end
        end
    end

    for (genvar go = 0; go < NUM_PORTS; go++) begin : g_out
        assign out_data[go*DATA_WIDTH +: DATA_WIDTH] = out_data_q[go];
    end

    assign out_send   = out_send_q;
    assign err_drop   = err_drop_q;
    assign flit_phase = phase_q;

`ifdef ROUTER_STATS_EN
    logic [15:0] stat_q [NUM_PORTS];
    logic [15:0] stat_d [NUM_PORTS];

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            stat_d[o] = stat_q[o];
            if (out_send_q[o] && out_ready[o] && (stat_q[o] != 16'hFFFF))
                stat_d[o] = stat_q[o] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int o = 0; o < NUM_PORTS; o++) stat_q[o] <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) stat_q[o] <= stat_d[o];
        end
    end

    for (genvar gs = 0; gs < NUM_PORTS; gs++) begin : g_stat
        assign stat_cnt[gs*16 +: 16] = stat_q[gs];
    end
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_mesh_router_xy.sv
// Directed bench for mesh_router_xy: a main node (0x0101, DEPTH 2) and an
// edge node (0x0101, DEPTH 1, east port masked) driven from vector tables.
module tb_mesh_router_xy;

    localparam int DW = 64;
    localparam int NP = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             polarity;
    logic [NP-1:0]    in_send, in_ready, out_send, out_ready;
    logic [NP*DW-1:0] in_data, out_data;
    logic             err_drop, flit_phase;
    logic [NP*16-1:0] stat_cnt;

    logic [NP-1:0]    e_in_send, e_in_ready, e_out_send, e_out_ready;
    logic [NP*DW-1:0] e_in_data, e_out_data;
    logic             e_err_drop, e_flit_phase;
    logic [NP*16-1:0] e_stat_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mesh_router_xy #(
        .DATA_WIDTH(DW), .DEPTH(2), .CURRENT_ADDRESS(16'h0101),
        .DST_LSB(32), .EDGE_MASK(5'b00000)
    ) dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .in_send(in_send), .in_data(in_data), .in_ready(in_ready),
        .out_send(out_send), .out_data(out_data), .out_ready(out_ready),
        .err_drop(err_drop), .flit_phase(flit_phase), .stat_cnt(stat_cnt)
    );

    mesh_router_xy #(
        .DATA_WIDTH(DW), .DEPTH(1), .CURRENT_ADDRESS(16'h0101),
        .DST_LSB(32), .EDGE_MASK(5'b00100)
    ) dut_edge (
        .clk(clk), .reset(reset), .polarity(polarity),
        .in_send(e_in_send), .in_data(e_in_data), .in_ready(e_in_ready),
        .out_send(e_out_send), .out_data(e_out_data), .out_ready(e_out_ready),
        .err_drop(e_err_drop), .flit_phase(e_flit_phase), .stat_cnt(e_stat_cnt)
    );

    typedef struct {
        int          src;
        logic [15:0] dest;
        int          port;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [63:0] mk_flit(input logic [15:0] dest, input logic [31:0] pl);
        return {16'hA5A5, dest, pl};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic [15:0] dest, input logic [31:0] pl);
        in_data[p*DW +: DW] = mk_flit(dest, pl);
        in_send[p] = 1'b1;
    endtask

    task automatic e_drive(input int p, input logic [15:0] dest, input logic [31:0] pl);
        e_in_data[p*DW +: DW] = mk_flit(dest, pl);
        e_in_send[p] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_send   = '0;
        e_in_send = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [63:0] got_flits [9];
    int          srcs [3];
    int          sent [NP];
    int          got, first_cyc, last_cyc, sent6;
    logic        others_seen;
    logic [15:0] exp_e_stat;

    initial begin
        vecs[0]  = '{4, 16'h0103, 2};
        vecs[1]  = '{4, 16'h0100, 3};
        vecs[2]  = '{4, 16'h0201, 1};
        vecs[3]  = '{4, 16'h0001, 0};
        vecs[4]  = '{4, 16'h0101, 4};
        vecs[5]  = '{0, 16'h0303, 2};
        vecs[6]  = '{1, 16'h0000, 3};
        vecs[7]  = '{2, 16'h0501, 1};
        vecs[8]  = '{3, 16'h0101, 4};
        vecs[9]  = '{4, 16'h00FF, 2};
        vecs[10] = '{2, 16'hFF01, 1};
        vecs[11] = '{3, 16'h02FF, 2};
        srcs = '{0, 1, 3};

        reset       = 1'b1;
        polarity    = 1'b0;
        in_send     = '0;
        in_data     = '0;
        out_ready   = '1;
        e_in_send   = '0;
        e_in_data   = '0;
        e_out_ready = '1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_out_send", 64'(out_send), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1F);
        check("rst_err_drop", 64'(err_drop), 64'h0);
        check("rst_phase", 64'(flit_phase), 64'h0);
        check("rst_out_data_e", out_data[2*DW +: DW], 64'h0);
        check("rst_stat", 64'(stat_cnt[63:0]), 64'h0);
        check("rst_edge_in_ready", 64'(e_in_ready), 64'h1F);

        // Routing table, one flit at a time, latency t+2.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].src, vecs[i].dest, 32'(i));
            @(negedge clk);
            in_send = '0;
            check($sformatf("v%0d_early", i), 64'(out_send), 64'h0);
            @(negedge clk);
            check($sformatf("v%0d_send", i), 64'(out_send), 64'(5'b1 << vecs[i].port));
            check($sformatf("v%0d_data", i), out_data[vecs[i].port*DW +: DW],
                  mk_flit(vecs[i].dest, 32'(i)));
            @(negedge clk);
            check($sformatf("v%0d_idle", i), 64'(out_send), 64'h0);
        end

`ifdef ROUTER_STATS_EN
        exp_e_stat = 16'd4;
`else
        exp_e_stat = 16'd0;
`endif
        check("stat_e_after_table", 64'(stat_cnt[2*16 +: 16]), 64'(exp_e_stat));

        polarity = 1'b1;
        @(negedge clk);
        check("phase_hi", 64'(flit_phase), 64'h1);
        polarity = 1'b0;
        @(negedge clk);
        check("phase_lo", 64'(flit_phase), 64'h0);

        // N, S, W all stream to E: expect N,S,W repeating, back to back.
        do_reset();
        got = 0; first_cyc = -1; last_cyc = -1; others_seen = 1'b0;
        for (int p = 0; p < NP; p++) sent[p] = 0;
        for (int cyc = 0; cyc < 40 && got < 9; cyc++) begin
            @(negedge clk);
            if (out_send[2]) begin
                got_flits[got] = out_data[2*DW +: DW];
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (|(out_send & 5'b11011)) others_seen = 1'b1;
            in_send = '0;
            for (int j = 0; j < 3; j++) begin
                if (sent[srcs[j]] < 3 && in_ready[srcs[j]]) begin
                    drive(srcs[j], 16'h0105, 32'(srcs[j]*16 + sent[srcs[j]]));
                    sent[srcs[j]]++;
                end
            end
        end
        in_send = '0;
        check("rr_count", 64'(got), 64'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < got)
                check($sformatf("rr_order%0d", i), got_flits[i],
                      mk_flit(16'h0105, 32'(srcs[i%3]*16 + i/3)));
        end
        check("rr_back_to_back", 64'(last_cyc - first_cyc), 64'd8);
        check("rr_no_stray", 64'(others_seen), 64'h0);

        // Backpressure on E with DEPTH 2.
        do_reset();
        out_ready = 5'b11011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_send = '0;
            if (in_ready[4]) drive(4, 16'h0103, 32'h100 + 32'(i));
        end
        @(negedge clk);
        in_send = '0;
        check("bp_pe_full", 64'(in_ready[4]), 64'h0);
        check("bp_send", 64'(out_send[2]), 64'h1);
        check("bp_data0", out_data[2*DW +: DW], mk_flit(16'h0103, 32'h100));
        @(negedge clk);
        check("bp_hold_send", 64'(out_send[2]), 64'h1);
        check("bp_hold_data", out_data[2*DW +: DW], mk_flit(16'h0103, 32'h100));
        out_ready = '1;
        @(negedge clk);
        check("bp_drain1", out_data[2*DW +: DW], mk_flit(16'h0103, 32'h101));
        check("bp_ready_back", 64'(in_ready[4]), 64'h1);
        @(negedge clk);
        check("bp_drain2", out_data[2*DW +: DW], mk_flit(16'h0103, 32'h102));
        check("bp_drain2_send", 64'(out_send[2]), 64'h1);
        @(negedge clk);
        check("bp_empty", 64'(out_send), 64'h0);

        // Edge drop on the masked east port.
        @(negedge clk);
        e_drive(4, 16'h0103, 32'h200);
        @(negedge clk);
        e_in_send = '0;
        check("edge_pre", 64'(e_err_drop), 64'h0);
        @(negedge clk);
        check("edge_pulse", 64'(e_err_drop), 64'h1);
        check("edge_no_out", 64'(e_out_send), 64'h0);
        @(negedge clk);
        check("edge_pulse_end", 64'(e_err_drop), 64'h0);
        e_drive(0, 16'h0202, 32'h201);
        e_drive(1, 16'h0202, 32'h202);
        @(negedge clk);
        e_in_send = '0;
        @(negedge clk);
        check("edge_dbl_pulse", 64'(e_err_drop), 64'h1);
        @(negedge clk);
        check("edge_dbl_single", 64'(e_err_drop), 64'h0);
        check("edge_ready", 64'(e_in_ready), 64'h1F);
        check("edge_dbl_no_out", 64'(e_out_send), 64'h0);
        e_drive(4, 16'h0100, 32'h203);
        @(negedge clk);
        e_in_send = '0;
        @(negedge clk);
        check("edge_w_send", 64'(e_out_send), 64'h08);
        check("edge_w_data", e_out_data[3*DW +: DW], mk_flit(16'h0100, 32'h203));
        check("edge_w_noerr", 64'(e_err_drop), 64'h0);

        // Mid-operation reset with flits buffered and E pointer moved off 0.
        out_ready = '0;
        @(negedge clk);
        drive(3, 16'h0105, 32'h300);
        @(negedge clk);
        in_send = '0;
        drive(3, 16'h0105, 32'h301);
        polarity = 1'b1;
        @(negedge clk);
        in_send = '0;
        check("mr_pre_send", 64'(out_send[2]), 64'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mr_out_send", 64'(out_send), 64'h0);
        check("mr_in_ready", 64'(in_ready), 64'h1F);
        check("mr_out_data", out_data[2*DW +: DW], 64'h0);
        check("mr_phase", 64'(flit_phase), 64'h0);
        check("mr_err", 64'(err_drop), 64'h0);
        polarity  = 1'b0;
        out_ready = '1;
        drive(0, 16'h0105, 32'h310);
        drive(4, 16'h0105, 32'h314);
        @(negedge clk);
        in_send = '0;
        @(negedge clk);
        check("mr_first_n", out_data[2*DW +: DW], mk_flit(16'h0105, 32'h310));
        @(negedge clk);
        check("mr_second_pe", out_data[2*DW +: DW], mk_flit(16'h0105, 32'h314));
        @(negedge clk);
        check("mr_no_stale", 64'(out_send), 64'h0);

        // Statistics counter.
        do_reset();
        check("stat_after_reset", 64'(stat_cnt), 64'h0);
`ifdef ROUTER_STATS_EN
        sent6 = 0;
        for (int cyc = 0; cyc < 70100 && sent6 < 70000; cyc++) begin
            @(negedge clk);
            in_send = '0;
            if (in_ready[4]) begin
                drive(4, 16'h0101, 32'(sent6));
                sent6++;
            end
        end
        @(negedge clk);
        in_send = '0;
        repeat (4) @(negedge clk);
        check("stat_sent", 64'(sent6), 64'd70000);
        check("stat_pe_sat", 64'(stat_cnt[4*16 +: 16]), 64'hFFFF);
        check("stat_e_zero", 64'(stat_cnt[2*16 +: 16]), 64'h0);
`else
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_send = '0;
            if (in_ready[4]) drive(4, 16'h0101, 32'(i));
        end
        @(negedge clk);
        in_send = '0;
        repeat (4) @(negedge clk);
        check("stat_disabled", 64'(stat_cnt), 64'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
